// File: rtl/pl19_pl20_accessory.sv
// Accessory end of the PL19/PL20 connector: serialises source characters to the CPU and
// assembles CPU output bits into sink characters. Define ACC_IN_FIFO_EN for a FIFO input buffer.
//
// state   | meaning
// I_IDLE  | input path stopped; buffer may still be filled by the source
// I_WAIT  | started; waiting for a buffered character to load
// I_READY | character loaded in ishreg; CPU shifts it out MSB first
module pl19_pl20_accessory #(
    parameter int CHAR_BITS  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLOCK,
    input  logic                 rst,
    input  logic                 PL19_START_INPUT,
    input  logic                 PL19_STOP_INPUT,
    input  logic                 PL19_SHIFT_CMD,
    output logic                 PL19_INPUT,
    output logic                 PL19_READY_IN,
    input  logic                 PL20_OUTPUT,
    input  logic                 PL20_OUTPUT_SHIFT,
    output logic                 PL20_READY_OUT,
    input  logic [CHAR_BITS-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [CHAR_BITS-1:0] snk_data,
    output logic                 snk_valid,
    input  logic                 snk_ready,
    output logic                 in_active,
    output logic                 overrun
);

    localparam int BW = $clog2(CHAR_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAR_BITS - 1);

    typedef enum logic [1:0] {
        I_IDLE  = 2'd0,
        I_WAIT  = 2'd1,
        I_READY = 2'd2
    } in_state_e;

    // Strobe history: {start, stop, shift, output_shift}
    logic [3:0] strobe_q, strobe_d, strobe_ev;
    logic       start_ev, stop_ev, shift_ev, oshift_ev;

    assign strobe_d  = {PL19_START_INPUT, PL19_STOP_INPUT, PL19_SHIFT_CMD, PL20_OUTPUT_SHIFT};
    assign strobe_ev = strobe_d & ~strobe_q;
    assign start_ev  = strobe_ev[3];
    assign stop_ev   = strobe_ev[2];
    assign shift_ev  = strobe_ev[1];
    assign oshift_ev = strobe_ev[0];

    logic                 buf_full, buf_empty, push, pop;
    logic [CHAR_BITS-1:0] buf_rdata;

    assign src_ready = !buf_full;
    assign push      = src_valid && !buf_full;

`ifdef ACC_IN_FIFO_EN
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    logic [CHAR_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [CHAR_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign buf_full  = (count_q == CNTW'(FIFO_DEPTH));
    assign buf_empty = (count_q == '0);
    assign buf_rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = src_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [CHAR_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;

    // A depth-0 configuration would never accept; otherwise FIFO_DEPTH plays no part here.
    assign buf_full  = hold_valid_q || (FIFO_DEPTH < 1);
    assign buf_empty = !hold_valid_q;
    assign buf_rdata = hold_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push) begin
            hold_d       = src_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    in_state_e            state_q, state_d;
    logic [CHAR_BITS-1:0] ishreg_q, ishreg_d;
    logic [BW-1:0]        ibit_q, ibit_d;
    logic                 pl19_input_q, pl19_input_d;
    logic                 ready_in_q, ready_in_d;
    logic                 in_active_q, in_active_d;

    always_comb begin
        state_d  = state_q;
        ishreg_d = ishreg_q;
        ibit_d   = ibit_q;
        pop      = 1'b0;
        if (stop_ev) begin
            state_d  = I_IDLE;
            ishreg_d = '0;
            ibit_d   = '0;
        end else begin
            case (state_q)
                I_IDLE: begin
                    if (start_ev) begin
                        state_d = I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (!buf_empty) begin
                        pop      = 1'b1;
                        ishreg_d = buf_rdata;
                        ibit_d   = '0;
                        state_d  = I_READY;
                    end
                end
                I_READY: begin
                    if (shift_ev) begin
                        ishreg_d = {ishreg_q[CHAR_BITS-2:0], 1'b0};
                        if (ibit_q == LAST_BIT) begin
                            ibit_d  = '0;
                            state_d = I_WAIT;
                        end else begin
                            ibit_d = ibit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = I_IDLE;
                end
            endcase
        end
    end

    // Outputs follow the registered state, so READY_IN rises two edges after a load request.
    assign ready_in_d   = (state_q == I_READY);
    assign pl19_input_d = (state_q == I_READY) && ishreg_q[CHAR_BITS-1];
    assign in_active_d  = (state_q != I_IDLE);

    logic [CHAR_BITS-2:0] oshreg_q, oshreg_d;
    logic [CHAR_BITS-1:0] char_next;
    logic [BW-1:0]        obit_q, obit_d;
    logic [CHAR_BITS-1:0] snk_data_q, snk_data_d;
    logic                 snk_valid_q, snk_valid_d;
    logic                 overrun_q, overrun_d;

    assign char_next = {oshreg_q, PL20_OUTPUT};

    always_comb begin
        oshreg_d    = oshreg_q;
        obit_d      = obit_q;
        snk_data_d  = snk_data_q;
        snk_valid_d = snk_valid_q;
        overrun_d   = overrun_q;
        if (snk_valid_q && snk_ready) begin
            snk_valid_d = 1'b0;
        end
        if (oshift_ev) begin
            if (!snk_valid_q) begin
                oshreg_d = char_next[CHAR_BITS-2:0];
                if (obit_q == LAST_BIT) begin
                    snk_data_d  = char_next;
                    snk_valid_d = 1'b1;
                    obit_d      = '0;
                end else begin
                    obit_d = obit_q + 1'b1;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            strobe_q     <= '0;
            state_q      <= I_IDLE;
            ishreg_q     <= '0;
            ibit_q       <= '0;
            pl19_input_q <= 1'b0;
            ready_in_q   <= 1'b0;
            in_active_q  <= 1'b0;
            oshreg_q     <= '0;
            obit_q       <= '0;
            snk_data_q   <= '0;
            snk_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            strobe_q     <= strobe_d;
            state_q      <= state_d;
            ishreg_q     <= ishreg_d;
            ibit_q       <= ibit_d;
            pl19_input_q <= pl19_input_d;
            ready_in_q   <= ready_in_d;
            in_active_q  <= in_active_d;
            oshreg_q     <= oshreg_d;
            obit_q       <= obit_d;
            snk_data_q   <= snk_data_d;
            snk_valid_q  <= snk_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign PL19_INPUT     = pl19_input_q;
    assign PL19_READY_IN  = ready_in_q;
    assign in_active      = in_active_q;
    assign snk_data       = snk_data_q;
    assign snk_valid      = snk_valid_q;
    assign overrun        = overrun_q;
    assign PL20_READY_OUT = !snk_valid_q;

endmodule

// File: tb/tb_pl19_pl20_accessory.sv
// Directed bench for pl19_pl20_accessory: output-path vector table plus input-path sequences.
// Buffer depth expectations follow ACC_IN_FIFO_EN.
module tb_pl19_pl20_accessory;

    localparam int CB = 5;
`ifdef ACC_IN_FIFO_EN
    localparam int BUF_DEPTH = 4;
`else
    localparam int BUF_DEPTH = 1;
`endif

    logic          CLOCK = 1'b0;
    logic          rst;
    logic          PL19_START_INPUT, PL19_STOP_INPUT, PL19_SHIFT_CMD;
    logic          PL19_INPUT, PL19_READY_IN;
    logic          PL20_OUTPUT, PL20_OUTPUT_SHIFT, PL20_READY_OUT;
    logic [CB-1:0] src_data;
    logic          src_valid, src_ready;
    logic [CB-1:0] snk_data;
    logic          snk_valid, snk_ready;
    logic          in_active, overrun;

    pl19_pl20_accessory #(.CHAR_BITS(CB), .FIFO_DEPTH(4)) dut (
        .CLOCK            (CLOCK),
        .rst              (rst),
        .PL19_START_INPUT (PL19_START_INPUT),
        .PL19_STOP_INPUT  (PL19_STOP_INPUT),
        .PL19_SHIFT_CMD   (PL19_SHIFT_CMD),
        .PL19_INPUT       (PL19_INPUT),
        .PL19_READY_IN    (PL19_READY_IN),
        .PL20_OUTPUT      (PL20_OUTPUT),
        .PL20_OUTPUT_SHIFT(PL20_OUTPUT_SHIFT),
        .PL20_READY_OUT   (PL20_READY_OUT),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .snk_data         (snk_data),
        .snk_valid        (snk_valid),
        .snk_ready        (snk_ready),
        .in_active        (in_active),
        .overrun          (overrun)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          b;
        logic          s;
        logic          r;
        logic          ev;
        logic [CB-1:0] ed;
        logic          erdy;
        logic          eov;
    } ovec_t;

    ovec_t tbl[$];

    task automatic tick();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic b, s, r, ev, input logic [CB-1:0] ed, input logic erdy, eov);
        ovec_t v;
        v = '{b: b, s: s, r: r, ev: ev, ed: ed, erdy: erdy, eov: eov};
        tbl.push_back(v);
    endtask

    task automatic push(input logic [CB-1:0] d);
        src_data  = d;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
    endtask

    task automatic pulse_start();
        PL19_START_INPUT = 1'b1;
        tick();
        PL19_START_INPUT = 1'b0;
        tick();
    endtask

    task automatic pulse_stop();
        PL19_STOP_INPUT = 1'b1;
        tick();
        PL19_STOP_INPUT = 1'b0;
        tick();
    endtask

    task automatic pl20_bit(input logic b);
        PL20_OUTPUT       = b;
        PL20_OUTPUT_SHIFT = 1'b1;
        tick();
        PL20_OUTPUT_SHIFT = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input int maxc);
        int n;
        n = 0;
        while (!PL19_READY_IN && n < maxc) begin
            tick();
            n++;
        end
        check("ready_in_wait", 32'(PL19_READY_IN), 32'd1);
    endtask

    task automatic shift_once(input int hold);
        PL19_SHIFT_CMD = 1'b1;
        repeat (hold) tick();
        PL19_SHIFT_CMD = 1'b0;
        tick();
    endtask

    task automatic read_char(input int hold, output logic [CB-1:0] c);
        c = '0;
        wait_ready(20);
        for (int i = 0; i < CB; i++) begin
            c = {c[CB-2:0], PL19_INPUT};
            shift_once(hold);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pl19_input"}, 32'(PL19_INPUT), 32'd0);
        check({tag, "_ready_in"}, 32'(PL19_READY_IN), 32'd0);
        check({tag, "_snk_valid"}, 32'(snk_valid), 32'd0);
        check({tag, "_in_active"}, 32'(in_active), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_snk_data"}, 32'(snk_data), 32'd0);
        check({tag, "_ready_out"}, 32'(PL20_READY_OUT), 32'd1);
        check({tag, "_src_ready"}, 32'(src_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CB-1:0] c;
        logic [CB-1:0] base;

        rst = 1'b1;
        PL19_START_INPUT = 1'b0; PL19_STOP_INPUT = 1'b0; PL19_SHIFT_CMD = 1'b0;
        PL20_OUTPUT = 1'b0; PL20_OUTPUT_SHIFT = 1'b0;
        src_data = '0; src_valid = 1'b0; snk_ready = 1'b0;
        tick();
        tick();
        check_reset_vals("init");
        rst = 1'b0;
        tick();

        // Output path: bits 0,1,1,0,1 drained; then 10011 held, overrun, then 11100.
        add(0,1,1, 0,5'b00000,1,0); add(0,0,1, 0,5'b00000,1,0);
        add(1,1,1, 0,5'b00000,1,0); add(1,0,1, 0,5'b00000,1,0);
        add(1,1,1, 0,5'b00000,1,0); add(1,0,1, 0,5'b00000,1,0);
        add(0,1,1, 0,5'b00000,1,0); add(0,0,1, 0,5'b00000,1,0);
        add(1,1,1, 1,5'b01101,0,0); add(1,0,1, 0,5'b01101,1,0);
        add(1,1,0, 0,5'b01101,1,0); add(1,0,0, 0,5'b01101,1,0);
        add(0,1,0, 0,5'b01101,1,0); add(0,0,0, 0,5'b01101,1,0);
        add(0,1,0, 0,5'b01101,1,0); add(0,0,0, 0,5'b01101,1,0);
        add(1,1,0, 0,5'b01101,1,0); add(1,0,0, 0,5'b01101,1,0);
        add(1,1,0, 1,5'b10011,0,0); add(1,0,0, 1,5'b10011,0,0);
        add(0,1,0, 1,5'b10011,0,1); add(0,0,0, 1,5'b10011,0,1);
        add(1,1,0, 1,5'b10011,0,1); add(1,0,1, 0,5'b10011,1,1);
        add(0,0,0, 0,5'b10011,1,1);
        add(1,1,1, 0,5'b10011,1,1); add(1,0,1, 0,5'b10011,1,1);
        add(1,1,1, 0,5'b10011,1,1); add(1,0,1, 0,5'b10011,1,1);
        add(1,1,1, 0,5'b10011,1,1); add(1,0,1, 0,5'b10011,1,1);
        add(0,1,1, 0,5'b10011,1,1); add(0,0,1, 0,5'b10011,1,1);
        add(0,1,1, 1,5'b11100,0,1); add(0,0,1, 0,5'b11100,1,1);

        foreach (tbl[i]) begin
            PL20_OUTPUT       = tbl[i].b;
            PL20_OUTPUT_SHIFT = tbl[i].s;
            snk_ready         = tbl[i].r;
            tick();
            check($sformatf("out_vec%0d", i),
                  32'({snk_valid, snk_data, PL20_READY_OUT, overrun}),
                  32'({tbl[i].ev, tbl[i].ed, tbl[i].erdy, tbl[i].eov}));
        end
        PL20_OUTPUT_SHIFT = 1'b0;
        snk_ready = 1'b1;

        // Load latency and serial order of 10110
        pulse_start();
        check("wait_in_active", 32'(in_active), 32'd1);
        push(5'b10110);
        check("lat_k", 32'(PL19_READY_IN), 32'd0);
        tick();
        check("lat_k1", 32'(PL19_READY_IN), 32'd0);
        tick();
        check("lat_k2", 32'(PL19_READY_IN), 32'd1);
        read_char(1, c);
        check("char_10110", 32'(c), 32'(5'b10110));
        check("ready_drop", 32'(PL19_READY_IN), 32'd0);
        repeat (3) tick();
        check("ready_stay_low", 32'(PL19_READY_IN), 32'd0);
        check("input_low", 32'(PL19_INPUT), 32'd0);

        // Stop mid-character, restart from buffer; held strobes act once
        pulse_stop();
        push(5'b11001);
        pulse_start();
        wait_ready(20);
        push(5'b00111);
        check("part_bit0", 32'(PL19_INPUT), 32'd1);
        shift_once(1);
        check("part_bit1", 32'(PL19_INPUT), 32'd1);
        shift_once(1);
        pulse_stop();
        check("stop_ready", 32'(PL19_READY_IN), 32'd0);
        check("stop_active", 32'(in_active), 32'd0);
        pulse_start();
        read_char(3, c);
        check("char_after_stop", 32'(c), 32'(5'b00111));
        PL19_START_INPUT = 1'b1; PL19_STOP_INPUT = 1'b1;
        tick();
        PL19_START_INPUT = 1'b0; PL19_STOP_INPUT = 1'b0;
        tick();
        check("startstop_active", 32'(in_active), 32'd0);
        push(5'b01010);
        repeat (6) tick();
        check("idle_no_load", 32'(PL19_READY_IN), 32'd0);
        PL19_START_INPUT = 1'b1; PL19_STOP_INPUT = 1'b1;
        tick();
        PL19_START_INPUT = 1'b0; PL19_STOP_INPUT = 1'b0;
        repeat (3) tick();
        check("startstop_idle_active", 32'(in_active), 32'd0);
        check("startstop_idle_ready", 32'(PL19_READY_IN), 32'd0);
        pulse_start();
        read_char(1, c);
        check("char_prefill", 32'(c), 32'(5'b01010));
        pulse_stop();

        // Fill buffer, reject extra, drain in order; second round wraps pointers
        for (int r = 0; r < 2; r++) begin
            base = (r == 0) ? 5'h11 : 5'h05;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                push(base + CB'(i));
            end
            check($sformatf("full_src_ready_r%0d", r), 32'(src_ready), 32'd0);
            push(5'h1f);
            pulse_start();
            for (int i = 0; i < BUF_DEPTH; i++) begin
                read_char(1, c);
                check($sformatf("fifo_r%0d_c%0d", r, i), 32'(c), 32'(base + CB'(i)));
            end
            repeat (4) tick();
            check($sformatf("fifo_r%0d_empty", r), 32'(PL19_READY_IN), 32'd0);
            check($sformatf("fifo_r%0d_src_ready", r), 32'(src_ready), 32'd1);
            pulse_stop();
        end

        // Reset mid-character on both paths, with overrun and snk_data non-zero
        push(5'b10101);
        pulse_start();
        wait_ready(20);
        shift_once(1);
        shift_once(1);
        push(5'b11111);
        snk_ready = 1'b0;
        pl20_bit(1'b1);
        pl20_bit(1'b1);
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("rst2");
        rst = 1'b0;
        tick();
        check_reset_vals("post_rst");
        pulse_start();
        repeat (8) tick();
        check("rst_buffer_empty", 32'(PL19_READY_IN), 32'd0);
        pl20_bit(1'b1);
        pl20_bit(1'b0);
        pl20_bit(1'b1);
        check("rst_no_partial", 32'(snk_valid), 32'd0);
        pl20_bit(1'b1);
        pl20_bit(1'b1);
        check("rst_new_char_valid", 32'(snk_valid), 32'd1);
        check("rst_new_char_data", 32'(snk_data), 32'(5'b10111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
